// File: rtl/bpb_update_ctrl_pkg.sv
// rtl/bpb_update_ctrl_pkg.sv - shared types for the BPB commit-side update scheduler
package bpb_update_ctrl_pkg;

    typedef logic [31:0] word_t;

    typedef struct packed {
        logic  taken;
        word_t destpc;
    } bpb_result_t;

    typedef struct packed {
        word_t       pc;
        bpb_result_t res;
    } bpb_update_t;

    localparam int BPB_UPD_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FLUSH  = 2'd2
    } upd_state_t;

endpackage

// File: rtl/bpb_upd_fifo.sv
// rtl/bpb_upd_fifo.sv - 2-write / 1-read circular buffer of BPB updates
module bpb_upd_fifo
    import bpb_update_ctrl_pkg::*;
#(
    parameter int DEPTH = BPB_UPD_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic [1:0]  wr_cnt,
    input  bpb_update_t wr_data0,
    input  bpb_update_t wr_data1,
    input  logic        pop,
    output bpb_update_t head_data,
    output logic [CW-1:0] count,
    output logic [CW-1:0] space
);

    localparam int PW = $clog2(DEPTH);

    bpb_update_t   mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] tail_inc;

    // DEPTH is a power of two, so pointer arithmetic wraps on its own
    assign tail_inc  = tail + PW'(1);
    assign head_data = mem[head];
    assign space     = CW'(DEPTH) - count + CW'(pop);

    always_ff @(posedge clk) begin
        if (!clear) begin
            if (wr_cnt != 2'd0) mem[tail]     <= wr_data0;
            if (wr_cnt == 2'd2) mem[tail_inc] <= wr_data1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PW'(pop);
            tail  <= tail + PW'(wr_cnt);
            count <= count + CW'(wr_cnt) - CW'(pop);
        end
    end

endmodule

// File: rtl/bpb_update_ctrl.sv
// rtl/bpb_update_ctrl.sv - queues up to two resolved branches per cycle and replays them in order to the BPB lines
module bpb_update_ctrl
    import bpb_update_ctrl_pkg::*;
#(
    parameter int DEPTH  = BPB_UPD_DEPTH,
    parameter int DROP_W = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     stall,
    input  logic                     clear,
    input  logic [1:0]               upd_valid,
    input  word_t [1:0]              upd_pc,
    input  bpb_result_t [1:0]        upd_result,
    output logic                     wen,
    output word_t                    pc_commit,
    output bpb_result_t              destpc_commit,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic                     q_full,
    output logic [DROP_W-1:0]        drop_cnt
);

    localparam int CW = $clog2(DEPTH) + 1;

    upd_state_t    state, state_nxt;
    logic          pop;
    logic          enq_en;
    logic          v1, v0, acc1, acc0;
    logic [1:0]    wr_cnt;
    logic [1:0]    drops;
    logic [CW-1:0] count, space, count_nxt;
    logic [DROP_W:0] drop_sum;
    bpb_update_t   slot1, slot0, wr_data0, head_data;

    assign slot1 = '{pc: upd_pc[1], res: upd_result[1]};
    assign slot0 = '{pc: upd_pc[0], res: upd_result[0]};

    assign wen = (state == ST_ACTIVE);
    assign pop = wen & ~stall;

    // Updates arriving with clear or during the flush cycle vanish without counting as drops
    assign enq_en = ~clear & (state != ST_FLUSH);
    assign v1     = enq_en & upd_valid[1];
    assign v0     = enq_en & upd_valid[0];
    assign acc1   = v1 && (space >= CW'(1));
    assign acc0   = v0 && (space >= (acc1 ? CW'(2) : CW'(1)));

    assign wr_cnt    = {1'b0, acc1} + {1'b0, acc0};
    assign wr_data0  = acc1 ? slot1 : slot0;
    assign drops     = {1'b0, v1 & ~acc1} + {1'b0, v0 & ~acc0};
    assign count_nxt = count + CW'(wr_cnt) - CW'(pop);
    assign drop_sum  = {1'b0, drop_cnt} + (DROP_W+1)'(drops);

    bpb_upd_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (clear),
        .wr_cnt    (wr_cnt),
        .wr_data0  (wr_data0),
        .wr_data1  (slot0),
        .pop       (pop),
        .head_data (head_data),
        .count     (count),
        .space     (space)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= ST_EMPTY;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (drop_sum[DROP_W]) drop_cnt <= '1;
            else                  drop_cnt <= drop_sum[DROP_W-1:0];
        end
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = ST_FLUSH;
        end else begin
            case (state)
                ST_EMPTY:  if (wr_cnt != 2'd0)  state_nxt = ST_ACTIVE;
                ST_ACTIVE: if (count_nxt == '0) state_nxt = ST_EMPTY;
                ST_FLUSH:  state_nxt = ST_EMPTY;
                default:   state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign q_count       = count;
    assign q_full        = (count == CW'(DEPTH));
    assign pc_commit     = (count != '0) ? head_data.pc  : '0;
    assign destpc_commit = (count != '0) ? head_data.res : '0;

endmodule
